// File: rtl/ext_af_pkg.sv
// ext_af_pkg
// Shared helpers for the external async FIFO controllers (write and read
// side): Gray/binary conversion and pointer geometry derived from ADDR_WIDTH.
// The conversion functions operate on a fixed wide word; callers zero-extend
// their pointer into it and truncate the result back. Leading zeros are
// neutral for both conversions, so any pointer width up to GRAY_MAX_W works.
package ext_af_pkg;

  localparam int GRAY_MAX_W = 32;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  // Pointers carry one extra MSB so full and empty are distinguishable.
  function automatic int ptr_width(input int addr_w);
    return addr_w + 1;
  endfunction

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/ext_af_wr_ctrl_if.sv
// ext_af_wr_ctrl_if
// Push handshake plus FIFO memory write port of the write-domain controller.
//   wr_valid  : push request                 (master -> slave)
//   wr_data   : push data                    (master -> slave)
//   wr_ready  : push can be accepted         (slave  -> master)
//   mem_we    : memory write enable          (slave  -> master)
//   mem_waddr : memory write address         (slave  -> master)
//   mem_wdata : inverted push data to store  (slave  -> master)
// The controller is the slave; the pushing client / memory side is the master.
interface ext_af_wr_ctrl_if #(
  parameter int FIFO_WIDTH = 1,
  parameter int ADDR_WIDTH = 4
);

  logic                  wr_valid;
  logic                  wr_ready;
  logic [FIFO_WIDTH-1:0] wr_data;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [FIFO_WIDTH-1:0] mem_wdata;

  modport slave (
    input  wr_valid, wr_data,
    output wr_ready, mem_we, mem_waddr, mem_wdata
  );

  modport master (
    output wr_valid, wr_data,
    input  wr_ready, mem_we, mem_waddr, mem_wdata
  );

endinterface

// File: rtl/ext_af_gray_sync.sv
// ext_af_gray_sync
// Flop chain that brings a Gray-coded pointer across a clock boundary.
// Shared by the write- and read-side controllers. STAGES must be at least 2.
// Ports:
//   i_clk : destination-domain clock
//   i_rst : synchronous, active-high reset (clears every stage)
//   i_d   : Gray pointer from the foreign domain
//   o_q   : synchronized Gray pointer (last stage)
module ext_af_gray_sync #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_chain [STAGES];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_chain[i] <= '0;
      end
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/ext_af_wr_ctrl.sv
// ext_af_wr_ctrl
// Write-domain controller of the external async FIFO. Accepts pushes on a
// valid/ready handshake, drives the memory write port with bit-inverted data
// (the read side recovers data as ~(empty | stored)), publishes a Gray write
// pointer and derives full / almost-full / occupancy from a synchronized copy
// of the read pointer.
// Ports:
//   wr_clk            : write-domain clock
//   wr_rst            : synchronous, active-high reset
//   bus (slave)       : wr_valid/wr_ready/wr_data push handshake and
//                       mem_we/mem_waddr/mem_wdata memory write port
//   rd_gray_ptr_async : Gray read pointer from the read clock domain
//   wr_gray_ptr       : published Gray write pointer (registered)
//   af_full           : FIFO full, write-domain view
//   af_almost_full    : occupancy >= AFULL_THRESH
//   af_wr_count       : occupancy; may over-report, never under-reports
module ext_af_wr_ctrl
  import ext_af_pkg::*;
#(
  parameter int FIFO_WIDTH   = 1,
  parameter int ADDR_WIDTH   = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 2
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  ext_af_wr_ctrl_if.slave       bus,
  input  logic [ADDR_WIDTH:0]   rd_gray_ptr_async,
  output logic [ADDR_WIDTH:0]   wr_gray_ptr,
  output logic                  af_full,
  output logic                  af_almost_full,
  output logic [ADDR_WIDTH:0]   af_wr_count
);

  localparam int PW    = ptr_width(ADDR_WIDTH);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam logic [PW-1:0] FULL_COUNT     = PW'(DEPTH);
  localparam logic [PW:0]   AFULL_THRESH_W = (PW+1)'(AFULL_THRESH);

  logic [PW-1:0]         r_wr_bin_ptr;
  logic [PW-1:0]         r_wr_gray_ptr;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_waddr;
  logic [FIFO_WIDTH-1:0] r_mem_wdata;

  logic [PW-1:0]         w_rd_gray_sync;
  logic [PW-1:0]         w_rd_bin_sync;
  logic [PW-1:0]         w_wr_count;
  logic                  w_full;
  logic                  w_accept;

  ext_af_gray_sync #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) DONT_TOUCH_gray_sync_inst (
    .i_clk (wr_clk),
    .i_rst (wr_rst),
    .i_d   (rd_gray_ptr_async),
    .o_q   (w_rd_gray_sync)
  );

  assign w_rd_bin_sync = PW'(gray2bin(GRAY_MAX_W'(w_rd_gray_sync)));

  // Modular difference; the extra pointer MSB makes a count of DEPTH
  // distinguishable from zero.
  assign w_wr_count = r_wr_bin_ptr - w_rd_bin_sync;
  assign w_full     = (w_wr_count == FULL_COUNT);
  assign w_accept   = bus.wr_valid & ~w_full;

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      r_wr_bin_ptr  <= '0;
      r_wr_gray_ptr <= '0;
      r_mem_we      <= 1'b0;
      r_mem_waddr   <= '0;
      r_mem_wdata   <= '0;
    end else begin
      // Publishing the pointer one edge behind the binary pointer lines it up
      // with the memory write edge, so the read side never sees a word
      // before it is stored. Binary steps by one, so Gray changes one bit.
      r_wr_gray_ptr <= PW'(bin2gray(GRAY_MAX_W'(r_wr_bin_ptr)));
      r_mem_we      <= w_accept;
      if (w_accept) begin
        r_wr_bin_ptr <= r_wr_bin_ptr + PW'(1);
        r_mem_waddr  <= r_wr_bin_ptr[ADDR_WIDTH-1:0];
        r_mem_wdata  <= ~bus.wr_data;
      end
    end
  end

  assign bus.wr_ready   = ~w_full;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_waddr  = r_mem_waddr;
  assign bus.mem_wdata  = r_mem_wdata;
  assign wr_gray_ptr    = r_wr_gray_ptr;
  assign af_full        = w_full;
  assign af_almost_full = ({1'b0, w_wr_count} >= AFULL_THRESH_W);
  assign af_wr_count    = w_wr_count;

endmodule

// File: tb/tb_ext_af_wr_ctrl.sv
module tb_ext_af_wr_ctrl;

  localparam int FW    = 8;
  localparam int AW    = 4;
  localparam int SS    = 2;
  localparam int TH    = 14;
  localparam int PW    = AW + 1;
  localparam int DEPTH = 1 << AW;
  localparam int PMOD  = 1 << PW;

  logic          wr_clk = 1'b0;
  logic          wr_rst = 1'b1;
  logic [PW-1:0] rd_gray_ptr_async = '0;
  logic [PW-1:0] wr_gray_ptr;
  logic [PW-1:0] af_wr_count;
  logic          af_full;
  logic          af_almost_full;

  int n_cmp = 0;
  int n_err = 0;

  ext_af_wr_ctrl_if #(.FIFO_WIDTH(FW), .ADDR_WIDTH(AW)) bus ();

  ext_af_wr_ctrl #(
    .FIFO_WIDTH   (FW),
    .ADDR_WIDTH   (AW),
    .SYNC_STAGES  (SS),
    .AFULL_THRESH (TH)
  ) u_dut (
    .wr_clk            (wr_clk),
    .wr_rst            (wr_rst),
    .bus               (bus.slave),
    .rd_gray_ptr_async (rd_gray_ptr_async),
    .wr_gray_ptr       (wr_gray_ptr),
    .af_full           (af_full),
    .af_almost_full    (af_almost_full),
    .af_wr_count       (af_wr_count)
  );

  always #5 wr_clk = ~wr_clk;

  // Reference model: pointers as plain integers, the read-pointer
  // synchronizer as a history of what the read side presented at each edge.
  int          m_wr     = 0;
  int          m_pub    = 0;
  int          m_rd     = 0;
  bit          m_we     = 1'b0;
  int          m_waddr  = 0;
  logic [FW-1:0] m_wdata = '0;
  int          m_writes = 0;
  int          dut_writes = 0;
  bit          last_acc = 1'b0;
  int          rd_hist[$];

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  function automatic int rd_sync();
    if (rd_hist.size() < SS) return 0;
    return rd_hist[rd_hist.size() - SS];
  endfunction

  function automatic int m_count();
    return (m_wr - rd_sync() + PMOD) % PMOD;
  endfunction

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    int c;
    c = m_count();
    if (bus.mem_we === 1'b1) dut_writes++;
    check_val({ph, ".mem_we"},    bus.mem_we,     m_we);
    check_val({ph, ".mem_waddr"}, bus.mem_waddr,  m_waddr);
    check_val({ph, ".mem_wdata"}, bus.mem_wdata,  m_wdata);
    check_val({ph, ".gray"},      wr_gray_ptr,    to_gray(m_pub));
    check_val({ph, ".count"},     af_wr_count,    c);
    check_val({ph, ".full"},      af_full,        (c == DEPTH));
    check_val({ph, ".afull"},     af_almost_full, (c >= TH));
    check_val({ph, ".ready"},     bus.wr_ready,   (c != DEPTH));
  endtask

  task automatic cycle(input bit rst, input bit v, input logic [FW-1:0] d, input string ph);
    bit acc;
    wr_rst            = rst;
    bus.wr_valid      = v;
    bus.wr_data       = d;
    rd_gray_ptr_async = PW'(to_gray(m_rd));
    acc = !rst && v && (m_count() != DEPTH);
    @(posedge wr_clk);
    if (rst) begin
      m_wr = 0; m_pub = 0; m_we = 1'b0; m_waddr = 0; m_wdata = '0;
      rd_hist.delete();
    end else begin
      m_pub = m_wr;
      m_we  = acc;
      if (acc) begin
        m_waddr = m_wr % DEPTH;
        m_wdata = ~d;
        m_wr    = (m_wr + 1) % PMOD;
        m_writes++;
      end
      rd_hist.push_back(m_rd);
    end
    last_acc = acc;
    @(negedge wr_clk);
    check_all(ph);
  endtask

  initial begin
    logic [PW-1:0] g0;
    bit pa;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;

    // Reset with a push held active
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, '1, "reset");
    check_val("reset.ready", bus.wr_ready, 1'b1);

    // Fill 16 words with the read pointer parked at 0
    for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, FW'(i), "fill");
    check_val("fill.full", af_full, 1'b1);
    cycle(1'b0, 1'b1, 8'h77, "fill_hold");
    check_val("fill.gray16", wr_gray_ptr, 5'b11000);
    check_val("fill.no_we_when_full", bus.mem_we, 1'b0);

    // Release: read pointer steps to 1
    m_rd = 1;
    cycle(1'b0, 1'b0, '0, "release");
    check_val("release.still_full", af_full, 1'b1);
    cycle(1'b0, 1'b0, '0, "release");
    check_val("release.full_drop", af_full, 1'b0);
    check_val("release.count15", af_wr_count, 15);

    // Push and read-pointer advance in the same cycle at count 15
    m_rd = 2;
    cycle(1'b0, 1'b1, 8'hC3, "simul");
    check_val("simul.full", af_full, 1'b1);
    cycle(1'b0, 1'b0, '0, "simul");
    cycle(1'b0, 1'b0, '0, "simul");
    check_val("simul.count15", af_wr_count, 15);
    check_val("simul.no_loss", dut_writes, m_writes);

    // Wrap: read side consumes whatever has been published
    for (int i = 0; i < 40; i++) begin
      g0 = wr_gray_ptr;
      pa = last_acc;
      m_rd = m_pub;
      cycle(1'b0, 1'b1, FW'($urandom), "wrap");
      check_val("wrap.gray_step", $countones(wr_gray_ptr ^ g0), pa);
    end

    // Reset mid-fill after 7 pushes (read domain reset alongside)
    m_rd = 0;
    cycle(1'b1, 1'b0, '0, "mid_rst");
    for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, FW'(8'h10 + i), "mid_fill");
    cycle(1'b1, 1'b1, 8'hEE, "mid_rst");
    check_val("mid_rst.we", bus.mem_we, 1'b0);
    check_val("mid_rst.count", af_wr_count, 0);
    cycle(1'b0, 1'b1, 8'hA5, "mid_push");
    check_val("mid_push.waddr", bus.mem_waddr, 0);
    check_val("mid_push.wdata", bus.mem_wdata, 8'h5A);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        m_rd = 0;
        cycle(1'b1, 1'($urandom_range(0, 1)), FW'($urandom), "rnd_rst");
      end else begin
        if (((m_pub - m_rd + PMOD) % PMOD) > 0 && $urandom_range(0, 9) < 4)
          m_rd = (m_rd + 1) % PMOD;
        cycle(1'b0, ($urandom_range(0, 9) < 7), FW'($urandom), "rnd");
      end
    end
    check_val("rnd.no_loss", dut_writes, m_writes);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
